sprite_line_buffer: RTL and testbench
=====================================

SPRITE_LINE_BUFFER -- requirements
Module: sprite_line_buffer

Interface
REQ-001 Parameter SCREEN_W, default 640, visible pixels per line.
REQ-002 Parameter H_TOTAL, default 800, hcount period; line end = hcount == H_TOTAL-1.
REQ-003 Parameter TRANSP_KEY, default 16'hF81F, pixel value that is never written.
REQ-004 clk  in  1  system clock, single clock domain.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 hcount  in  10  current scan column, 0..H_TOTAL-1.
REQ-007 wr_en  in  1  sprite pixel write strobe from sprite engine.
REQ-008 wr_col  in  10  target column of write.
REQ-009 wr_data  in  16  RGB565 pixel of write.
REQ-010 eng_done  in  1  sprite engine row-complete level.
REQ-011 sprite_start  out  1  one-cycle pulse telling sprite engine to build next row.
REQ-012 pix_valid  out  1  sprite pixel present at scan column.
REQ-013 pix_data  out  16  sprite pixel for scan column, 0 when pix_valid=0.
REQ-014 overrun  out  1  sticky: line ended before engine finished.

Function
REQ-015 Two banks, each SCREEN_W x 16 data plus SCREEN_W valid flops; bank_sel selects write bank, other bank is read bank.
REQ-016 At every line end, bank_sel toggles; the bank just filled becomes read bank for the following line.
REQ-017 Write accepted when wr_en=1, wr_col < SCREEN_W, wr_data != TRANSP_KEY: data stored, valid bit set; otherwise write ignored.
REQ-018 Multiple writes to one column in a line: last write wins.
REQ-019 Write in the line-end cycle targets the pre-toggle write bank.
REQ-020 Read: for hcount < SCREEN_W, pix_valid/pix_data reflect read bank column hcount with exactly 1 cycle latency (registered outputs).
REQ-021 For hcount >= SCREEN_W, pix_valid=0, pix_data=0 on the next cycle.
REQ-022 Clear-on-read: the cycle a read-bank column is addressed, its valid bit clears, so the bank is empty when it becomes write bank.
REQ-023 Reads and writes always hit different banks; no same-address collision exists.
REQ-024 FSM states IDLE, START, DRAW, WAIT.
REQ-025 IDLE -> START on first line end after reset.
REQ-026 START: sprite_start=1 for exactly one cycle, -> DRAW.
REQ-027 DRAW: eng_done ignored in its first cycle; afterwards eng_done=1 -> WAIT.
REQ-028 WAIT -> START on line end.
REQ-029 Line end while in DRAW: overrun set to 1, FSM -> START; overrun stays 1 until reset.
REQ-030 Line end while in START (H_TOTAL=1 degenerate) not supported; H_TOTAL >= 4 required.
REQ-031 sprite_start is asserted only from START; never two pulses within one line.

Reset
REQ-032 reset_n=0 asynchronously: FSM=IDLE, bank_sel=0, all valid bits=0, sprite_start=0, pix_valid=0, pix_data=0, overrun=0.
REQ-033 Reset mid-line discards both banks; first output line after reset shows no sprites.
REQ-034 Data RAM contents need no reset; valid bits alone gate output.

Structure
REQ-035 Shared package sprite_pkg holds SCREEN_W, H_TOTAL, TRANSP_KEY defaults and the FSM state enum typedef.
REQ-036 One sub-module sprite_line_bank: SCREEN_W x 16 simple dual-port RAM, registered read, instantiated twice.
REQ-037 Valid bits kept in flops in the top level, not in RAM.

Verification
REQ-038 Reset then two line ends, no writes -> exactly one sprite_start per line, pix_valid=0 over all 800 columns.
REQ-039 Line N: write col 5 = 16'h1234, col 639 = 16'hABCD, eng_done after 100 cycles -> line N+1: pix_valid=1, pix_data=16'h1234 one cycle after hcount=5, 16'hABCD after hcount=639, zero elsewhere; line N+2 all zero.
REQ-040 Write col 10 = 16'hF81F, col 640 = 16'h0001 -> neither appears on next line.
REQ-041 Writes col 20 = 16'h0001 then 16'h0002 same line -> next line shows 16'h0002 at col 20.
REQ-042 eng_done held 0 through line end -> overrun=1 and stays 1; new sprite_start issued; eng_done=1 during first DRAW cycle ignored.
REQ-043 reset_n pulsed low at hcount=300 after a filled line -> outputs 0 immediately, next line blank, overrun=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared defaults, widths and FSM state type for the sprite line buffer.
package sprite_pkg;

  localparam int COL_W = 10;
  localparam int PIX_W = 16;

  localparam int              SCREEN_W_DEF   = 640;
  localparam int              H_TOTAL_DEF    = 800;
  localparam logic [PIX_W-1:0] TRANSP_KEY_DEF = 16'hF81F;

  // Sprite engine sequencing: kick the engine, let it draw, wait for line end.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DRAW  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // A pixel is stored only if it is strobed, on screen and not the colour key.
  function automatic logic write_ok(
    input logic             wr_en,
    input logic [COL_W-1:0] wr_col,
    input logic [PIX_W-1:0] wr_data,
    input logic [COL_W-1:0] screen_w,
    input logic [PIX_W-1:0] key
  );
    return wr_en && (wr_col < screen_w) && (wr_data != key);
  endfunction

endpackage

// File: rtl/sprite_line_buffer_if.sv
// Scan/sprite-engine side signals of the sprite line buffer.
interface sprite_line_buffer_if;
  import sprite_pkg::*;

  logic [COL_W-1:0] hcount;
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic [PIX_W-1:0] wr_data;
  logic             eng_done;
  logic             sprite_start;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             overrun;

  // Video timing / sprite engine side.
  modport master (
    output hcount, wr_en, wr_col, wr_data, eng_done,
    input  sprite_start, pix_valid, pix_data, overrun
  );

  // Line buffer side.
  modport slave (
    input  hcount, wr_en, wr_col, wr_data, eng_done,
    output sprite_start, pix_valid, pix_data, overrun
  );

endinterface

// File: rtl/sprite_line_bank.sv
// One line of pixel storage: simple dual-port RAM, one write port, one
// registered read port. No reset; the valid flops in the parent gate output.
module sprite_line_bank #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port plus registered read, the shape block RAM inference expects.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite line buffer: the sprite engine fills one bank while the
// scan-out reads the other; banks swap at every line end.
module sprite_line_buffer
  import sprite_pkg::*;
#(
  parameter int              SCREEN_W   = SCREEN_W_DEF,
  parameter int              H_TOTAL    = H_TOTAL_DEF,
  parameter logic [PIX_W-1:0] TRANSP_KEY = TRANSP_KEY_DEF
) (
  input logic                 clk,
  input logic                 reset_n,
  sprite_line_buffer_if.slave bus
);

  localparam int               AW         = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam logic [COL_W-1:0] SCREEN_W_C = COL_W'(SCREEN_W);
  localparam logic [COL_W-1:0] LINE_END_C = COL_W'(H_TOTAL - 1);

  // Bank bookkeeping
  logic             bank_sel_q;   // bank currently being written
  logic             rd_bank_q;    // bank whose data reaches pix_data this cycle
  logic             pix_valid_q;

  // FSM
  state_e           state_q;
  logic             sprite_start_q;
  logic             overrun_q;
  logic             draw_first_q; // first DRAW cycle, eng_done not yet trusted

  // Decoded per-cycle controls
  logic             line_end;
  logic             rd_active;
  logic             wr_ok;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid_w [2];
  logic [PIX_W-1:0] rd_data_w  [2];

  assign line_end  = (bus.hcount == LINE_END_C);
  assign rd_active = (bus.hcount < SCREEN_W_C);
  assign wr_ok     = write_ok(bus.wr_en, bus.wr_col, bus.wr_data, SCREEN_W_C, TRANSP_KEY);

  // Park the addresses at zero when idle so off-screen columns never index
  // past the end of a bank.
  assign wr_addr = wr_ok     ? bus.wr_col[AW-1:0] : '0;
  assign rd_addr = rd_active ? bus.hcount[AW-1:0] : '0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic                we;
      logic                re;
      logic [SCREEN_W-1:0] valid_q;

      // This bank is written while selected and read while not, so the two
      // ports of one bank are never active in the same cycle.
      assign we = wr_ok     && (bank_sel_q == 1'(gi));
      assign re = rd_active && (bank_sel_q != 1'(gi));

      sprite_line_bank #(
        .DEPTH (SCREEN_W),
        .WIDTH (PIX_W),
        .AW    (AW)
      ) u_bank (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_addr),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data_w[gi])
      );

      // Valid flags: set on accepted write, cleared as the scan reads them so
      // the bank is empty by the time it becomes the write bank again.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_q <= '0;
        end else begin
          if (re) begin
            valid_q[rd_addr] <= 1'b0;
          end
          if (we) begin
            valid_q[wr_addr] <= 1'b1;
          end
        end
      end

      assign rd_valid_w[gi] = re && valid_q[rd_addr];
    end
  endgenerate

  // Swap write/read banks at the end of every line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_sel_q <= 1'b0;
    end else if (line_end) begin
      bank_sel_q <= ~bank_sel_q;
    end
  end

  // Register the valid flag alongside the RAM's registered read so both
  // arrive together one cycle after the column is addressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_q <= 1'b0;
      rd_bank_q   <= 1'b0;
    end else begin
      pix_valid_q <= rd_valid_w[0] || rd_valid_w[1];
      rd_bank_q   <= ~bank_sel_q;
    end
  end

  // Sprite engine sequencing with registered sprite_start and sticky overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      sprite_start_q <= 1'b0;
      overrun_q      <= 1'b0;
      draw_first_q   <= 1'b0;
    end else begin
      sprite_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (line_end) begin
            state_q        <= ST_START;
            sprite_start_q <= 1'b1;
          end
        end
        ST_START: begin
          state_q      <= ST_DRAW;
          draw_first_q <= 1'b1;
        end
        ST_DRAW: begin
          draw_first_q <= 1'b0;
          if (line_end) begin
            // Engine still drawing when the line ran out: flag it and restart.
            overrun_q      <= 1'b1;
            state_q        <= ST_START;
            sprite_start_q <= 1'b1;
          end else if (!draw_first_q && bus.eng_done) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (line_end) begin
            state_q        <= ST_START;
            sprite_start_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sprite_start = sprite_start_q;
  assign bus.overrun      = overrun_q;
  assign bus.pix_valid    = pix_valid_q;
  assign bus.pix_data     = pix_valid_q ? rd_data_w[rd_bank_q] : '0;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed bench for sprite_line_buffer: full 800-column lines with scheduled
// writes and hand-written expected pixel maps for the following line.
module tb_sprite_line_buffer;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  sprite_line_buffer_if bus();

  sprite_line_buffer #(
    .SCREEN_W   (640),
    .H_TOTAL    (800),
    .TRANSP_KEY (16'hF81F)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          cyc;
    int          col;
    logic [15:0] data;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  logic        exp_v [640];
  logic [15:0] exp_d [640];
  wr_t         wq [$];
  int          eng_lo = 100;
  int          eng_hi = 799;
  logic        exp_ovr = 1'b0;
  int          starts;

  task automatic clear_exp();
    for (int i = 0; i < 640; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = 16'h0000;
    end
  endtask

  task automatic set_exp(input int col, input logic [15:0] d);
    exp_v[col] = 1'b1;
    exp_d[col] = d;
  endtask

  task automatic add_wr(input int cyc, input int col, input logic [15:0] d);
    wr_t w;
    w.cyc  = cyc;
    w.col  = col;
    w.data = d;
    wq.push_back(w);
  endtask

  // Drive hcount 0..last_h, apply queued writes, check every output column.
  task automatic run_line(input string tag, input int last_h);
    starts = 0;
    for (int h = 0; h <= last_h; h++) begin
      logic        ev;
      logic [15:0] ed;
      bus.hcount  = 10'(h);
      bus.wr_en   = 1'b0;
      bus.wr_col  = 10'd0;
      bus.wr_data = 16'h0000;
      foreach (wq[i]) begin
        if (wq[i].cyc == h) begin
          bus.wr_en   = 1'b1;
          bus.wr_col  = 10'(wq[i].col);
          bus.wr_data = wq[i].data;
        end
      end
      bus.eng_done = (h >= eng_lo) && (h <= eng_hi);
      @(posedge clk);
      #1;
      ev = (h < 640) ? exp_v[h] : 1'b0;
      ed = (h < 640) ? exp_d[h] : 16'h0000;
      total++;
      if (bus.pix_valid !== ev || bus.pix_data !== ed) begin
        bad++;
        $display("FAIL %s pixel col=%0d got valid=%b data=%h want valid=%b data=%h",
                 tag, h, bus.pix_valid, bus.pix_data, ev, ed);
      end
      if (bus.sprite_start === 1'b1) starts++;
    end
    bus.wr_en    = 1'b0;
    bus.eng_done = 1'b0;
    wq.delete();
  endtask

  // Per-line checks: one sprite_start per line, overrun as expected.
  task automatic end_checks(input string tag);
    total++;
    if (starts != 1) begin
      bad++;
      $display("FAIL %s start_count got %0d want 1", tag, starts);
    end
    total++;
    if (bus.overrun !== exp_ovr) begin
      bad++;
      $display("FAIL %s overrun got %b want %b", tag, bus.overrun, exp_ovr);
    end
    $display("line %s: starts=%0d overrun=%b", tag, starts, bus.overrun);
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if (bus.sprite_start !== 1'b0) begin
      bad++;
      $display("FAIL %s sprite_start got %b want 0", tag, bus.sprite_start);
    end
    total++;
    if (bus.pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s pix_valid got %b want 0", tag, bus.pix_valid);
    end
    total++;
    if (bus.pix_data !== 16'h0000) begin
      bad++;
      $display("FAIL %s pix_data got %h want 0000", tag, bus.pix_data);
    end
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL %s overrun got %b want 0", tag, bus.overrun);
    end
    $display("%s: sprite_start=%b pix_valid=%b pix_data=%h overrun=%b",
             tag, bus.sprite_start, bus.pix_valid, bus.pix_data, bus.overrun);
  endtask

  task automatic test_reset();
    bus.hcount   = 10'd0;
    bus.wr_en    = 1'b0;
    bus.wr_col   = 10'd0;
    bus.wr_data  = 16'h0000;
    bus.eng_done = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_zero_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_held");
    reset_n = 1'b1;
    clear_exp();
  endtask

  task automatic test_idle_lines();
    run_line("idle_l1", 799);
    end_checks("idle_l1");
    run_line("idle_l2", 799);
    end_checks("idle_l2");
  endtask

  task automatic test_basic_write();
    add_wr(50, 5, 16'h1234);
    add_wr(60, 639, 16'hABCD);
    run_line("basic_fill", 799);
    end_checks("basic_fill");
    set_exp(5, 16'h1234);
    set_exp(639, 16'hABCD);
    run_line("basic_show", 799);
    end_checks("basic_show");
    clear_exp();
    run_line("basic_cleared", 799);
    end_checks("basic_cleared");
  endtask

  task automatic test_rejects();
    add_wr(40, 10, 16'hF81F);
    add_wr(41, 640, 16'h0001);
    add_wr(42, 11, 16'h5555);
    run_line("reject_fill", 799);
    end_checks("reject_fill");
    set_exp(11, 16'h5555);
    run_line("reject_show", 799);
    end_checks("reject_show");
    clear_exp();
  endtask

  task automatic test_last_wins();
    add_wr(30, 20, 16'h0001);
    add_wr(40, 20, 16'h0002);
    run_line("lastwin_fill", 799);
    end_checks("lastwin_fill");
    set_exp(20, 16'h0002);
    run_line("lastwin_show", 799);
    end_checks("lastwin_show");
    clear_exp();
  endtask

  task automatic test_line_end_write();
    add_wr(799, 600, 16'h0F0F);
    run_line("lineend_fill", 799);
    end_checks("lineend_fill");
    set_exp(600, 16'h0F0F);
    run_line("lineend_show", 799);
    end_checks("lineend_show");
    clear_exp();
  endtask

  task automatic test_overrun();
    // eng_done only during the first DRAW cycle, which must be ignored.
    eng_lo = 1;
    eng_hi = 1;
    run_line("overrun_line", 799);
    exp_ovr = 1'b1;
    end_checks("overrun_line");
    eng_lo = 100;
    eng_hi = 799;
    run_line("overrun_sticky", 799);
    end_checks("overrun_sticky");
  endtask

  task automatic test_reset_mid();
    add_wr(20, 5, 16'h1111);
    add_wr(21, 300, 16'h2222);
    add_wr(22, 500, 16'h3333);
    run_line("midrst_fill", 799);
    end_checks("midrst_fill");
    set_exp(5, 16'h1111);
    set_exp(300, 16'h2222);
    set_exp(500, 16'h3333);
    add_wr(100, 400, 16'h4444);
    run_line("midrst_partial", 300);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("midrst_async");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_ovr = 1'b0;
    clear_exp();
    run_line("midrst_after1", 799);
    end_checks("midrst_after1");
    run_line("midrst_after2", 799);
    end_checks("midrst_after2");
  endtask

  initial begin
    test_reset();
    test_idle_lines();
    test_basic_write();
    test_rejects();
    test_last_wins();
    test_line_end_write();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
